// File: rtl/uart_pkg.sv
// Definitions shared by the UART blocks of the camera/plotter link:
// transmitter state encoding, parity mode codes and default frame geometry.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_SAMPLING   = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1..2 stop bits,
// paced by the shared oversampled baud tick; bytes arrive over valid/ready.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int SAMPLING   = UART_SAMPLING,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  b_tick,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TICK_W = $clog2(SAMPLING);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLING - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_tx_state_e        state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;

  assign bit_end = b_tick && (tick_q == TICK_LAST);

  always_comb begin
    // NOTE: every variable gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_done = 1'b0;

    // Tick counting is common to every bit of the frame; IDLE never counts.
    if (state_q != ST_IDLE && b_tick) begin
      tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            tx_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is derived from the next state so each bit edge lands
  // exactly one clk after the tick that closes the previous bit.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three instances (no parity / even / odd + 2 stop)
// checked against a tick-counting frame model of the serial line.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int S        = 16;
  localparam int DW       = 8;
  localparam int NU       = 3;
  localparam int CAP_MAX  = 4000;
  localparam int WAIT_MAX = 2000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          b_tick = 1'b0;
  logic [NU-1:0] tx_valid = '0;
  logic [DW-1:0] tx_data [NU];
  logic [NU-1:0] tx_ready, tx, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_per = 4;
  int tick_div = 0;
  bit tick_en = 1'b1;

  typedef struct {
    logic [15:0] bits;
    int          t_fall;
    int          t_end;
    int          glitches;
    int          hs_err;
    int          done_cnt;
    int          stray_done;
    bit          done_at_end;
    bit          timeout;
  } frame_t;

  uart_tx_engine #(.DATA_WIDTH(DW), .SAMPLING(S), .PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
  uart_tx_engine #(.DATA_WIDTH(DW), .SAMPLING(S), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
  uart_tx_engine #(.DATA_WIDTH(DW), .SAMPLING(S), .PARITY(PAR_ODD), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  always #5 clk = ~clk;

  // Free-running baud tick, one pulse every tick_per clks, changed just after posedge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (tick_en) begin
        tick_div++;
        if (tick_div >= tick_per) begin
          tick_div = 0;
          b_tick = 1'b1;
        end else begin
          b_tick = 1'b0;
        end
      end else begin
        b_tick = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int par_of(input int u);
    case (u)
      1:       return PAR_EVEN;
      2:       return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic int stop_of(input int u);
    return (u == 2) ? 2 : 1;
  endfunction

  function automatic int nbits_of(input int u);
    return 1 + DW + ((par_of(u) != PAR_NONE) ? 1 : 0) + stop_of(u);
  endfunction

  // Expected line levels, one entry per bit period, straight from the frame format.
  function automatic logic [15:0] exp_bits(input int u, input logic [DW-1:0] d);
    logic [15:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 0; i < DW; i++) begin
      b[p] = d[i];
      p++;
    end
    if (par_of(u) != PAR_NONE) begin
      b[p] = (($countones(d) % 2) == 1) ^ (par_of(u) == PAR_ODD);
      p++;
    end
    for (int s = 0; s < stop_of(u); s++) begin
      b[p] = 1'b1;
      p++;
    end
    return b;
  endfunction

  // Raise valid with a byte and hold it until accepted; returns in the first
  // frame cycle, before its negedge.
  task automatic send(input int u, input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    @(posedge clk);
    #1;
    tx_valid[u] = 1'b1;
    tx_data[u]  = d;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (tx_ready[u] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tx_valid[u] = 1'b0;
  endtask

  // Observe one frame: bit k is whatever tx shows after k*S ticks have elapsed
  // since the line fell; the frame ends on the cycle holding the last tick.
  task automatic capture_frame(input int u, output frame_t f);
    int n;
    int idx;
    int total;
    logic [15:0] seen;
    bit found;
    f = '{default: 0};
    total = nbits_of(u) * S;
    seen = '0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < CAP_MAX && !found; i++) begin
      @(negedge clk);
      if (tx[u] === 1'b0) found = 1'b1;
      else if (tx_done[u] === 1'b1) f.stray_done++;
    end
    if (!found) begin
      f.timeout = 1'b1;
      return;
    end
    f.t_fall = cyc;
    for (int i = 0; i < CAP_MAX; i++) begin
      if (i > 0) @(negedge clk);
      idx = n / S;
      if (!seen[idx]) begin
        seen[idx] = 1'b1;
        f.bits[idx] = tx[u];
      end else if (f.bits[idx] !== tx[u]) begin
        f.glitches++;
      end
      if (tx_busy[u] !== 1'b1 || tx_ready[u] !== 1'b0) f.hs_err++;
      if (b_tick) n++;
      if (tx_done[u] === 1'b1) begin
        f.done_cnt++;
        if (b_tick && n == total) f.done_at_end = 1'b1;
      end
      if (n == total) begin
        f.t_end = cyc;
        return;
      end
    end
    f.timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({tx[u], tx_busy[u], tx_ready[u], tx_done[u]} !== 4'b1010)
        begin failures++; $display("FAIL reset_outputs u%0d: tx/busy/ready/done=%b expected 1010", u, {tx[u], tx_busy[u], tx_ready[u], tx_done[u]}); end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({tx[u], tx_busy[u], tx_ready[u], tx_done[u]} !== 4'b1010)
        begin failures++; $display("FAIL idle_after_reset u%0d: tx/busy/ready/done=%b expected 1010", u, {tx[u], tx_busy[u], tx_ready[u], tx_done[u]}); end
    end
  endtask

  task automatic test_basic_frame();
    frame_t f;
    bit ok;
    int len;
    tick_per = 4;
    send(0, 8'h55, ok);
    capture_frame(0, f);
    len = f.t_end - f.t_fall + 1;
    checks++;
    if (!ok || f.timeout || f.bits !== exp_bits(0, 8'h55))
      begin failures++; $display("FAIL basic_bits: ok=%0d timeout=%0d bits=%h expected %h", ok, f.timeout, f.bits, exp_bits(0, 8'h55)); end
    checks++;
    if (f.glitches != 0 || f.hs_err != 0)
      begin failures++; $display("FAIL basic_stable: glitches=%0d busy/ready errors=%0d expected 0/0", f.glitches, f.hs_err); end
    checks++;
    if (f.done_cnt != 1 || !f.done_at_end)
      begin failures++; $display("FAIL basic_done: pulses=%0d at_end=%0d expected 1/1", f.done_cnt, f.done_at_end); end
    checks++;
    if (len < (10 * S - 1) * 4 + 1 || len > 10 * S * 4)
      begin failures++; $display("FAIL basic_length: %0d clks expected %0d..%0d", len, (10 * S - 1) * 4 + 1, 10 * S * 4); end
    @(negedge clk);
    checks++;
    if ({tx[0], tx_ready[0], tx_busy[0], tx_done[0]} !== 4'b1100)
      begin failures++; $display("FAIL basic_return_idle: tx/ready/busy/done=%b expected 1100", {tx[0], tx_ready[0], tx_busy[0], tx_done[0]}); end
  endtask

  task automatic test_parity();
    frame_t f;
    bit ok;
    int len;
    logic [DW-1:0] d;
    tick_per = 4;
    send(1, 8'h07, ok);
    capture_frame(1, f);
    checks++;
    if (!ok || f.timeout || f.bits[9] !== 1'b1 || f.bits !== exp_bits(1, 8'h07))
      begin failures++; $display("FAIL even_parity_07: parity=%b bits=%h expected parity 1 bits %h", f.bits[9], f.bits, exp_bits(1, 8'h07)); end
    send(2, 8'h07, ok);
    capture_frame(2, f);
    len = f.t_end - f.t_fall + 1;
    checks++;
    if (!ok || f.timeout || f.bits[9] !== 1'b0 || f.bits !== exp_bits(2, 8'h07))
      begin failures++; $display("FAIL odd_parity_07: parity=%b bits=%h expected parity 0 bits %h", f.bits[9], f.bits, exp_bits(2, 8'h07)); end
    checks++;
    if (f.done_cnt != 1 || !f.done_at_end || f.glitches != 0 || len < (12 * S - 1) * 4 + 1 || len > 12 * S * 4)
      begin failures++; $display("FAIL two_stop_timing: done=%0d at_end=%0d glitches=%0d len=%0d expected 1/1/0/%0d..%0d", f.done_cnt, f.done_at_end, f.glitches, len, (12 * S - 1) * 4 + 1, 12 * S * 4); end
    for (int i = 0; i < 6; i++) begin
      d = DW'($urandom);
      send(1 + (i % 2), d, ok);
      capture_frame(1 + (i % 2), f);
      checks++;
      if (!ok || f.timeout || f.bits !== exp_bits(1 + (i % 2), d) || f.done_cnt != 1)
        begin failures++; $display("FAIL parity_random u%0d data=%h: bits=%h done=%0d expected %h done 1", 1 + (i % 2), d, f.bits, f.done_cnt, exp_bits(1 + (i % 2), d)); end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    int gap;
    tick_per = 4;
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hA5;
    @(posedge clk);
    #1;
    tx_data[0]  = 8'h3C;
    capture_frame(0, f1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    capture_frame(0, f2);
    gap = f2.t_fall - f1.t_end - 1;
    checks++;
    if (f1.timeout || f1.bits !== exp_bits(0, 8'hA5))
      begin failures++; $display("FAIL b2b_first: bits=%h expected %h", f1.bits, exp_bits(0, 8'hA5)); end
    checks++;
    if (f2.timeout || f2.bits !== exp_bits(0, 8'h3C))
      begin failures++; $display("FAIL b2b_second: bits=%h expected %h", f2.bits, exp_bits(0, 8'h3C)); end
    checks++;
    if (gap != 1)
      begin failures++; $display("FAIL b2b_gap: idle clks=%0d expected 1", gap); end
    checks++;
    if (f1.hs_err != 0 || f2.hs_err != 0 || f1.done_cnt != 1 || f2.done_cnt != 1 || f2.stray_done != 0)
      begin failures++; $display("FAIL b2b_handshake: ready/busy errs=%0d/%0d dones=%0d/%0d stray=%0d expected 0/0/1/1/0", f1.hs_err, f2.hs_err, f1.done_cnt, f2.done_cnt, f2.stray_done); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    bit ok;
    int n;
    int bad;
    logic [DW-1:0] rst_bytes [2];
    rst_bytes[0] = 8'hFF;
    rst_bytes[1] = 8'h00;
    tick_per = 4;
    for (int k = 0; k < 2; k++) begin
      send(0, rst_bytes[k], ok);
      n = 0;
      for (int i = 0; i < CAP_MAX && n < 4 * S + 6; i++) begin
        @(negedge clk);
        if (b_tick) n++;
      end
      checks++;
      if (!ok || tx_busy[0] !== 1'b1 || tx[0] !== rst_bytes[k][3])
        begin failures++; $display("FAIL pre_reset_bit3 data=%h: busy=%b tx=%b expected 1/%b", rst_bytes[k], tx_busy[0], tx[0], rst_bytes[k][3]); end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({tx[0], tx_busy[0], tx_ready[0], tx_done[0]} !== 4'b1010)
        begin failures++; $display("FAIL reset_async data=%h: tx/busy/ready/done=%b expected 1010", rst_bytes[k], {tx[0], tx_busy[0], tx_ready[0], tx_done[0]}); end
      bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (tx[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_busy[0] !== 1'b0) bad++;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (S * 4 * 3) begin
        @(negedge clk);
        if (tx[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_busy[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0)
        begin failures++; $display("FAIL reset_discard data=%h: %0d cycles with activity, expected 0", rst_bytes[k], bad); end
    end
    send(0, 8'h81, ok);
    capture_frame(0, f);
    checks++;
    if (!ok || f.timeout || f.bits !== exp_bits(0, 8'h81) || f.done_cnt != 1)
      begin failures++; $display("FAIL after_reset_81: bits=%h done=%0d expected %h done 1", f.bits, f.done_cnt, exp_bits(0, 8'h81)); end
  endtask

  task automatic test_tick_stall();
    frame_t f;
    bit ok;
    int changes;
    int len;
    logic lvl;
    logic [DW-1:0] d;
    tick_per = 4;
    d = DW'($urandom);
    changes = 0;
    send(1, d, ok);
    fork
      capture_frame(1, f);
      begin
        repeat (200) @(negedge clk);
        tick_en = 1'b0;
        @(posedge clk);
        #2;
        lvl = tx[1];
        repeat (1000) begin
          @(negedge clk);
          if (tx[1] !== lvl || tx_busy[1] !== 1'b1 || tx_done[1] !== 1'b0) changes++;
        end
        tick_en = 1'b1;
      end
    join
    len = f.t_end - f.t_fall + 1;
    checks++;
    if (changes != 0)
      begin failures++; $display("FAIL stall_frozen: %0d cycles changed while ticks stopped, expected 0", changes); end
    checks++;
    if (!ok || f.timeout || f.bits !== exp_bits(1, d) || f.glitches != 0 || f.done_cnt != 1 || !f.done_at_end)
      begin failures++; $display("FAIL stall_resume data=%h: bits=%h glitches=%0d done=%0d expected %h/0/1", d, f.bits, f.glitches, f.done_cnt, exp_bits(1, d)); end
    checks++;
    if (len < 1000 + (11 * S - 1) * 4)
      begin failures++; $display("FAIL stall_length: %0d clks expected at least %0d", len, 1000 + (11 * S - 1) * 4); end
  endtask

  task automatic test_random_loopback();
    frame_t f;
    bit ok;
    int u;
    int done_total;
    logic [DW-1:0] d;
    done_total = 0;
    tick_per = 2;
    for (int i = 0; i < 256; i++) begin
      if (i == 16) tick_per = 1;
      if (failures > 20) break;
      u = i % NU;
      d = DW'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(u, d, ok);
      capture_frame(u, f);
      done_total += f.done_cnt;
      checks++;
      if (!ok || f.timeout || f.bits[DW:1] !== d || f.bits !== exp_bits(u, d))
        begin failures++; $display("FAIL rand_frame %0d u%0d: byte=%h bits=%h expected byte %h bits %h", i, u, f.bits[DW:1], f.bits, d, exp_bits(u, d)); end
      checks++;
      if (f.glitches != 0 || f.hs_err != 0 || f.done_cnt != 1 || !f.done_at_end)
        begin failures++; $display("FAIL rand_timing %0d u%0d: glitches=%0d hs=%0d done=%0d at_end=%0d expected 0/0/1/1", i, u, f.glitches, f.hs_err, f.done_cnt, f.done_at_end); end
    end
    checks++;
    if (done_total != 256)
      begin failures++; $display("FAIL rand_done_count: %0d expected 256", done_total); end
  endtask

  initial begin
    for (int u = 0; u < NU; u++) tx_data[u] = '0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_stall();
    test_random_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
